// File: rtl/boot_loader_pkg.sv
// Shared header-field positions, address step and FSM state type for the boot loader.
package boot_loader_pkg;

  localparam int unsigned HDR_LAST_BIT   = 31;
  localparam int unsigned HDR_TARGET_BIT = 30;
  localparam int unsigned HDR_ADDR_LSB   = 16;
  localparam int unsigned ADDR_STEP      = 4;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_LOAD,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/boot_loader_csum.sv
// Running checksum for the boot loader: clear on header, accumulate payload, compare.
module loader_csum #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] cmp,
  output logic                  match
);

  logic [DATA_WIDTH-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc) begin
      sum <= sum + din;
    end
  end

  assign match = (sum == cmp);

endmodule

// File: rtl/boot_loader.sv
// Header-driven multi-section loader for instruction/data BRAMs; releases the core when done.
// Optional per-section checksum checking is built when BOOT_LOADER_CSUM_EN is defined.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  d_bram_init_done,
  output logic                  rd_enbl,
  output logic                  load_err
);

  state_t                state;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  hdr_cnt;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [CNT_WIDTH-1:0]  remain;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_q;
  logic                  target_q;

  assign accept   = s_valid && s_ready;
  assign hdr_cnt  = s_data[CNT_WIDTH-1:0];
  assign hdr_addr = {s_data[HDR_ADDR_LSB+ADDR_WIDTH-1:HDR_ADDR_LSB+2], 2'b00};

`ifdef BOOT_LOADER_CSUM_EN
  logic csum_match;

  loader_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept && (state == ST_HEADER)),
    .acc   (accept && (state == ST_LOAD)),
    .din   (s_data),
    .cmp   (s_data),
    .match (csum_match)
  );
`else
  assign load_err = 1'b0;
`endif

  // Write strobes default low each cycle so enables are single-cycle pulses and
  // address/data read as zero whenever no write is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_HEADER;
      s_ready          <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      pc_stall         <= 1'b1;
      d_bram_init_done <= 1'b0;
      rd_enbl          <= 1'b0;
      remain           <= '0;
      addr_q           <= '0;
      last_q           <= 1'b0;
      target_q         <= 1'b0;
`ifdef BOOT_LOADER_CSUM_EN
      load_err         <= 1'b0;
`endif
    end else begin
      i_w_addr <= '0;
      i_w_dat  <= '0;
      i_w_enb  <= 1'b0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
      d_w_enb  <= 1'b0;
      case (state)
        ST_HEADER: begin
          s_ready <= 1'b1;
          if (accept) begin
            last_q   <= s_data[HDR_LAST_BIT];
            target_q <= s_data[HDR_TARGET_BIT];
            addr_q   <= hdr_addr;
            remain   <= hdr_cnt;
            if (hdr_cnt != '0) begin
              state <= ST_LOAD;
            end else if (s_data[HDR_LAST_BIT]) begin
`ifdef BOOT_LOADER_CSUM_EN
              state <= ST_CSUM;
`else
              state            <= ST_RUN;
              s_ready          <= 1'b0;
              pc_stall         <= 1'b0;
              d_bram_init_done <= 1'b1;
              rd_enbl          <= 1'b1;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (target_q) begin
              d_w_addr <= addr_q;
              d_w_dat  <= s_data;
              d_w_enb  <= 1'b1;
            end else begin
              i_w_addr <= addr_q;
              i_w_dat  <= s_data;
              i_w_enb  <= 1'b1;
            end
            addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            remain <= remain - CNT_WIDTH'(1);
            if (remain == CNT_WIDTH'(1)) begin
`ifdef BOOT_LOADER_CSUM_EN
              state <= ST_CSUM;
`else
              if (last_q) begin
                state            <= ST_RUN;
                s_ready          <= 1'b0;
                pc_stall         <= 1'b0;
                d_bram_init_done <= 1'b1;
                rd_enbl          <= 1'b1;
              end else begin
                state <= ST_HEADER;
              end
`endif
            end
          end
        end
`ifdef BOOT_LOADER_CSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (!csum_match) begin
              state    <= ST_ERROR;
              s_ready  <= 1'b0;
              load_err <= 1'b1;
            end else if (last_q) begin
              state            <= ST_RUN;
              s_ready          <= 1'b0;
              pc_stall         <= 1'b0;
              d_bram_init_done <= 1'b1;
              rd_enbl          <= 1'b1;
            end else begin
              state <= ST_HEADER;
            end
          end
        end
        ST_ERROR: ;
`endif
        ST_RUN: ;
        default: state <= ST_HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random images against a write-log model.
module tb_boot_loader;

`ifdef BOOT_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic        pc_stall, d_bram_init_done, rd_enbl, load_err;

  boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .i_w_addr         (i_w_addr),
    .i_w_dat          (i_w_dat),
    .i_w_enb          (i_w_enb),
    .d_w_addr         (d_w_addr),
    .d_w_dat          (d_w_dat),
    .d_w_enb          (d_w_enb),
    .pc_stall         (pc_stall),
    .d_bram_init_done (d_bram_init_done),
    .rd_enbl          (rd_enbl),
    .load_err         (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int run_cyc  = -1;
  int last_wr_cyc = -1;

  logic [41:0] i_log[$], d_log[$], exp_i[$], exp_d[$];
  logic [31:0] img[$];

  // Reference model state for the section currently being built
  bit          m_tgt;
  int          m_addr, m_n, m_k;
  logic [31:0] m_sum;
  logic [31:0] corrupt = '0;
  bit          final_pay = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (i_w_enb) begin
      i_log.push_back({i_w_addr, i_w_dat});
      last_wr_cyc = cyc;
    end
    if (d_w_enb) begin
      d_log.push_back({d_w_addr, d_w_dat});
      last_wr_cyc = cyc;
    end
    if (i_w_enb || d_w_enb) chk("wen_onehot", 64'(i_w_enb & d_w_enb), 64'd0);
    if (rst_n && !pc_stall && run_cyc < 0) run_cyc = cyc;
  end

  task automatic add_hdr(input logic [31:0] h);
    img.push_back(h);
    m_tgt  = h[30];
    m_addr = int'(h[25:16]) & 'h3FC;
    m_n    = int'(h[15:0]);
    m_k    = 0;
    m_sum  = '0;
    if (h[31]) final_pay = (m_n > 0);
    if (CSUM_ON && m_n == 0 && h[31]) img.push_back(32'd0 + corrupt);
  endtask

  task automatic add_word(input logic [31:0] w);
    img.push_back(w);
    if (m_tgt) exp_d.push_back({10'(m_addr), w});
    else       exp_i.push_back({10'(m_addr), w});
    m_addr = (m_addr + 4) % 1024;
    m_sum  = m_sum + w;
    m_k++;
    if (CSUM_ON && m_k == m_n) img.push_back(m_sum + corrupt);
  endtask

  task automatic add_section(input bit last, input bit tgt, input int start, input int n);
    add_hdr({last, tgt, 4'b0000, 10'(start), 16'(n)});
    for (int k = 0; k < n; k++) add_word($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_i_w"}, {21'd0, i_w_addr, i_w_dat, i_w_enb}, 64'd0);
    chk({tag, "_d_w"}, {21'd0, d_w_addr, d_w_dat, d_w_enb}, 64'd0);
    chk({tag, "_pc_stall"}, 64'(pc_stall), 64'd1);
    chk({tag, "_init_done"}, 64'(d_bram_init_done), 64'd0);
    chk({tag, "_rd_enbl"}, 64'(rd_enbl), 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'd0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    i_log.delete(); d_log.delete(); exp_i.delete(); exp_d.delete(); img.delete();
    run_cyc = -1; last_wr_cyc = -1; corrupt = '0; final_pay = 1'b0;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", 64'(s_ready), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    int b = 0;
    while (!s_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic finish_image(input string tag, input bit gap, input bit expect_err);
    foreach (img[k]) begin
      send_word(img[k]);
      if (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_i_count"}, 64'(i_log.size()), 64'(exp_i.size()));
    chk({tag, "_d_count"}, 64'(d_log.size()), 64'(exp_d.size()));
    for (int k = 0; k < exp_i.size() && k < i_log.size(); k++)
      chk({tag, "_i_wr"}, 64'(i_log[k]), 64'(exp_i[k]));
    for (int k = 0; k < exp_d.size() && k < d_log.size(); k++)
      chk({tag, "_d_wr"}, 64'(d_log[k]), 64'(exp_d[k]));
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_wen_idle"}, {62'd0, i_w_enb, d_w_enb}, 64'd0);
    chk({tag, "_waddr_idle"}, {44'd0, i_w_addr, d_w_addr}, 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'(expect_err));
    chk({tag, "_pc_stall"}, 64'(pc_stall), 64'(expect_err));
    chk({tag, "_init_done"}, 64'(d_bram_init_done), 64'(!expect_err));
    chk({tag, "_rd_enbl"}, 64'(rd_enbl), 64'(!expect_err));
    if (!expect_err && final_pay)
      chk({tag, "_run_timing"}, 64'(run_cyc), 64'(last_wr_cyc + (CSUM_ON ? 1 : 0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Two-section image: instruction then data, last
    do_reset();
    add_hdr(32'h0000_0003);
    repeat (3) add_word($urandom);
    add_hdr(32'hC000_0002);
    add_word(32'h0000_000A);
    add_word(32'h0000_000B);
    finish_image("two_sec", 1'b0, 1'b0);

    // Address wrap at the top of the data BRAM
    do_reset();
    add_hdr(32'hC3FC_0002);
    add_word($urandom);
    add_word($urandom);
    finish_image("wrap", 1'b0, 1'b0);

    // Valid dropped every other cycle during LOAD
    do_reset();
    add_section(1'b1, 1'b0, 'h100, 5);
    finish_image("gap", 1'b1, 1'b0);

    // Asynchronous reset after 2 of 5 words, then a clean reload
    do_reset();
    add_hdr(32'h8000_0005);
    repeat (5) add_word($urandom);
    for (int k = 0; k < 3; k++) send_word(img[k]);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    do_reset();
    add_section(1'b0, 1'b1, 'h040, 3);
    add_section(1'b1, 1'b0, 'h000, 5);
    finish_image("reload", 1'b0, 1'b0);

    // Empty sections only
    do_reset();
    add_hdr(32'h0000_0000);
    add_hdr(32'h8000_0000);
    finish_image("empty", 1'b0, 1'b0);

    // Random multi-section images, odd start bits and zero-length sections included
    for (int r = 0; r < 4; r++) begin
      int nsec;
      do_reset();
      nsec = $urandom_range(1, 3);
      for (int s = 0; s < nsec; s++)
        add_section(s == nsec - 1, 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                    $urandom_range(0, 5));
      finish_image("rand", r[0], 1'b0);
    end

`ifdef BOOT_LOADER_CSUM_EN
    do_reset();
    add_hdr(32'h8000_0002);
    add_word(32'd1);
    add_word(32'd2);
    finish_image("csum_ok", 1'b0, 1'b0);

    do_reset();
    corrupt = 32'd1;
    add_hdr(32'h8000_0002);
    add_word(32'd1);
    add_word(32'd2);
    finish_image("csum_bad", 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
